// File: rtl/bus_ready_generator_if.sv
// Command-side bus signals shared by the READY generator and its bus master.
// The master drives the arbitrated strobes and ownership; the slave returns READYs.
interface bus_ready_generator_if;
  logic address_enable_n;
  logic dma_wait_n;
  logic io_read_n;
  logic io_write_n;
  logic memory_read_n;
  logic memory_write_n;
  logic io_channel_ready;
  logic timeout_clear;
  logic processor_ready;
  logic dma_ready;
  logic wait_active;
  logic bus_timeout;

  modport master (
    output address_enable_n, dma_wait_n, io_read_n, io_write_n,
    output memory_read_n, memory_write_n, io_channel_ready, timeout_clear,
    input  processor_ready, dma_ready, wait_active, bus_timeout
  );

  modport slave (
    input  address_enable_n, dma_wait_n, io_read_n, io_write_n,
    input  memory_read_n, memory_write_n, io_channel_ready, timeout_clear,
    output processor_ready, dma_ready, wait_active, bus_timeout
  );
endinterface

// File: rtl/bus_ready_generator.sv
// Wait-state / READY generator on the command side of the bus arbiter.
// Inserts fixed wait clocks per cycle type, then stretches on the synchronized
// expansion-channel ready, with a bounded timeout so a stuck card cannot hang
// the bus. READY goes low only for the current bus owner (CPU or DMA).
module bus_ready_generator #(
  parameter int IO_WAIT_STATES  = 1,
  parameter int MEM_WAIT_STATES = 0,
  parameter int DMA_WAIT_STATES = 1,
  parameter int TIMEOUT_CYCLES  = 1023
) (
  input  logic                  clock,
  input  logic                  reset,
  bus_ready_generator_if.slave  bus
);

  localparam int MAX_IO_MEM = (IO_WAIT_STATES > MEM_WAIT_STATES) ? IO_WAIT_STATES : MEM_WAIT_STATES;
  localparam int MAX_WAIT   = (MAX_IO_MEM > DMA_WAIT_STATES) ? MAX_IO_MEM : DMA_WAIT_STATES;
  localparam int CNT_RAW    = $clog2(MAX_WAIT + 1);
  localparam int CNT_W      = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam int TMO_RAW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TMO_W      = (TMO_RAW < 1) ? 1 : TMO_RAW;

  localparam logic [CNT_W-1:0] IO_N     = CNT_W'(IO_WAIT_STATES);
  localparam logic [CNT_W-1:0] MEM_N    = CNT_W'(MEM_WAIT_STATES);
  localparam logic [CNT_W-1:0] DMA_N    = CNT_W'(DMA_WAIT_STATES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TMO_W-1:0] TMO_ZERO = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_CHANNEL = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [TMO_W-1:0] r_tmo;
  logic [TMO_W-1:0] w_tmo_next;
  logic             r_owner;
  logic             w_owner_next;
  logic             w_set_timeout;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_cmd_d;
  logic             w_cmd;
  logic             w_start;
  logic [CNT_W-1:0] w_wait_n;
  logic             w_owner_low;
  logic             w_cpu_rdy_next;
  logic             w_dma_rdy_next;
  logic             r_proc_ready;
  logic             r_dma_ready;
  logic             r_wait_active;
  logic             r_bus_timeout;

  // Wait count for a new cycle: DMA ownership dominates, then I/O beats memory.
  function automatic logic [CNT_W-1:0] select_wait(input logic dma_owner, input logic io_cycle);
    logic [CNT_W-1:0] n;
    if (dma_owner) begin
      n = DMA_N;
    end else if (io_cycle) begin
      n = IO_N;
    end else begin
      n = MEM_N;
    end
    return n;
  endfunction

  assign w_cmd    = ~(bus.io_read_n & bus.io_write_n & bus.memory_read_n & bus.memory_write_n);
  assign w_start  = w_cmd & ~r_cmd_d;
  assign w_wait_n = select_wait(bus.address_enable_n, ~(bus.io_read_n & bus.io_write_n));

  // Two-flop synchronizer for the asynchronous channel ready, plus command edge history.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cmd_d <= 1'b0;
    end else begin
      r_sync1 <= bus.io_channel_ready;
      r_sync2 <= r_sync1;
      r_cmd_d <= w_cmd;
    end
  end

  // Next-state, counter and timeout decisions for the wait-state sequencer.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_tmo_next    = r_tmo;
    w_owner_next  = r_owner;
    w_set_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_owner_next = bus.address_enable_n;
          w_tmo_next   = TMO_ZERO;
          if (w_wait_n != CNT_ZERO) begin
            w_state_next = ST_COUNT;
            w_cnt_next   = w_wait_n;
          end else begin
            w_state_next = ST_CHANNEL;
            w_cnt_next   = CNT_ZERO;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (!w_cmd) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = CNT_ZERO;
        end else if (r_cnt == CNT_ONE) begin
          w_state_next = ST_CHANNEL;
          w_cnt_next   = CNT_ZERO;
          w_tmo_next   = TMO_ZERO;
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      ST_CHANNEL: begin
        if (!w_cmd) begin
          w_state_next = ST_IDLE;
          w_tmo_next   = TMO_ZERO;
        end else if (r_sync2) begin
          w_state_next = ST_DONE;
        end else if (r_tmo == TMO_LAST) begin
          w_state_next  = ST_DONE;
          w_set_timeout = 1'b1;
        end else begin
          w_tmo_next = r_tmo + TMO_ONE;
        end
      end
      ST_DONE: begin
        if (!w_cmd) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = CNT_ZERO;
        w_tmo_next   = TMO_ZERO;
      end
    endcase
  end

  // READY is computed from the next state so it moves on the same edge as the FSM.
  always_comb begin
    w_owner_low    = (w_state_next == ST_COUNT) || (w_state_next == ST_CHANNEL);
    w_cpu_rdy_next = ~(w_owner_low & ~w_owner_next);
    w_dma_rdy_next = ~(w_owner_low & w_owner_next);
  end

  // State register, counters and owner latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_ZERO;
      r_tmo   <= TMO_ZERO;
      r_owner <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_tmo   <= w_tmo_next;
      r_owner <= w_owner_next;
    end
  end

  // Registered outputs; CPU READY is also held low while a DMA handover is pending.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_proc_ready  <= 1'b1;
      r_dma_ready   <= 1'b1;
      r_wait_active <= 1'b0;
    end else begin
      r_proc_ready  <= w_cpu_rdy_next & bus.dma_wait_n;
      r_dma_ready   <= w_dma_rdy_next;
      r_wait_active <= w_owner_low;
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bus_timeout <= 1'b0;
    end else if (w_set_timeout) begin
      r_bus_timeout <= 1'b1;
    end else if (bus.timeout_clear) begin
      r_bus_timeout <= 1'b0;
    end else begin
      r_bus_timeout <= r_bus_timeout;
    end
  end

  assign bus.processor_ready = r_proc_ready;
  assign bus.dma_ready       = r_dma_ready;
  assign bus.wait_active     = r_wait_active;
  assign bus.bus_timeout     = r_bus_timeout;

endmodule
